dma_write_engine: RTL and testbench
===================================

// Module: dma_write_engine
// PURPOSE
//   Bus-master DMA engine on memory port 2. Accepts a block-transfer command from the CPU,
//   requests the bus (br/bg), copies device-buffer qwords into memory with the port-2
//   ready/ack handshake (write_q), then releases the bus and pulses an interrupt to the CPU.
//   Sits between the CPU (command, bus grant) and the Memory port-2 interface.
// PARAMETERS
//   WORD_SIZE        16  address / word width
//   QWORD_SIZE       64  data beat width (4 words)
//   WORDS_PER_QWORD  4   address increment per beat
//   MAX_BEATS        16  device buffer depth in qwords; counter width = $clog2(MAX_BEATS)+1
// PORTS
//   clk          in   1   system clock, all state updates on posedge
//   reset_n      in   1   asynchronous, active-low reset
//   cmd_valid    in   1   CPU command strobe; accepted only when cmd_ready=1
//   cmd_ready    out  1   engine idle, can accept a command
//   cmd_addr     in   16  memory start address (word address)
//   cmd_length   in   16  transfer length in words; low 2 bits ignored
//   br           out  1   bus request to CPU
//   bg           in   1   bus grant from CPU
//   write_q      out  1   qword write request to memory port 2
//   address      out  16  memory word address of current beat
//   qdata        out  64  write data of current beat (= dev_qdata)
//   mem_ready    in   1   memory port 2 idle / able to accept
//   mem_ack      in   1   memory completed current qword write (1-cycle pulse)
//   dev_index    out  4   device buffer read index of current beat
//   dev_qdata    in   64  device buffer data at dev_index (combinational)
//   dma_done     out  1   interrupt, 1-cycle pulse at end of transfer
//   busy         out  1   high from command accept until dma_done cycle inclusive
// BEHAVIOUR
//   Reset: state=IDLE; cmd_ready=1; br, write_q, dma_done, busy=0; address, dev_index=0;
//     qdata follows dev_qdata. Reset mid-transfer drops br/write_q immediately; no resume.
//   Command accept: cmd_valid&cmd_ready at posedge latches addr, beats=cmd_length>>2
//     (saturate at MAX_BEATS), dev_index=0. beats==0 -> DONE next cycle, br never asserted.
//   States:
//     IDLE  cmd_ready=1. accept -> REQ (beats>0) or DONE (beats==0). cmd_valid ignored elsewhere.
//     REQ   br=1. bg=1 sampled -> ISSUE.
//     ISSUE br=1. mem_ready=1 & bg=1 -> write_q=1 same cycle, -> WAIT. bg=0 -> REQ.
//     WAIT  br=1, write_q=1; address/qdata/dev_index held stable until mem_ack.
//           mem_ack=1: address+=4 (16-bit wrap, 0xFFFC->0x0000), dev_index+=1, beats-=1;
//           beats becomes 0 -> RELEASE, else -> ISSUE.
//     RELEASE br=0, write_q=0; wait bg=0 -> DONE (CPU must see br low before grant drop).
//     DONE  dma_done=1 one cycle, busy=1 -> IDLE.
//   Latency: grant to first write_q = 1 cycle min; one beat per mem_ack; after last ack,
//     br falls next cycle, dma_done 1 cycle after bg observed low.
//   bg dropped while in WAIT: write is not aborted; beat completes on mem_ack, then -> REQ
//     (br stays high) instead of ISSUE. bg dropped in ISSUE: no write issued, -> REQ.
//   mem_ack outside WAIT ignored. mem_ack and bg fall in same cycle: beat counted, -> REQ.
//   No write_q ever asserted while bg=0 at issue time; at most one write outstanding.
// STRUCTURE
//   Shared package dma_pkg: WORD_SIZE/QWORD_SIZE defines, state encoding
//     (IDLE, REQ, ISSUE, WAIT, RELEASE, DONE), WORDS_PER_QWORD.
//   One sub-module: dma_beat_counter (address, dev_index, beats; load/step/zero flag).
//   FSM and output decode in this module; all outputs registered except qdata passthrough.
// TESTING
//   1 reset_n low mid-WAIT -> br, write_q, busy=0 async; cmd_ready=1 after release.
//   2 addr=0x0017,len=12,bg 1 cycle after br, ack 2 cycles after write_q -> 3 writes at
//     0x0017,0x001B,0x001F with dev_index 0,1,2; br low after 3rd ack; one dma_done pulse.
//   3 len=0 (and len=3) -> dma_done 2 cycles after accept; br and write_q never high.
//   4 addr=0xFFFC,len=8 -> writes at 0xFFFC then 0x0000.
//   5 bg dropped while WAIT on beat 1 of 3 -> beat 1 still acked/counted, br stays 1,
//     no write_q until bg returns; total exactly 3 writes, no duplicate address.
//   6 cmd_valid pulsed while busy with addr=0x0100 -> ignored; original transfer unaffected;
//     mem_ready held low 5 cycles -> write_q not asserted until mem_ready=1.

Source files
------------

// File: rtl/dma_write_engine_pkg.sv
// ---------------------------------------------------------------------------
// dma_write_engine_pkg
//   Shared widths, state encoding and helpers for the port-2 DMA write engine.
//   No ports; imported by the interface, the beat counter and the top.
// ---------------------------------------------------------------------------
package dma_write_engine_pkg;

    localparam int WORD_SIZE       = 16;
    localparam int QWORD_SIZE      = 64;
    localparam int WORDS_PER_QWORD = 4;
    localparam int MAX_BEATS       = 16;
    localparam int BEAT_CNT_W      = $clog2(MAX_BEATS) + 1;
    localparam int DEV_IDX_W       = $clog2(MAX_BEATS);
    localparam int STATE_W         = 3;

    typedef logic [WORD_SIZE-1:0]  word_t;
    typedef logic [QWORD_SIZE-1:0] qword_t;
    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;
    typedef logic [DEV_IDX_W-1:0]  dev_idx_t;
    typedef logic [STATE_W-1:0]    state_t;

    // Engine states, kept as plain constants so the encoding stays fixed
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_REQ     = 3'd1;
    localparam state_t ST_ISSUE   = 3'd2;
    localparam state_t ST_WAIT    = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
    localparam state_t ST_DONE    = 3'd5;

    // Word length to qword beats: the partial qword (low bits) is dropped and
    // the result is clamped to the depth of the device buffer.
    function automatic beat_cnt_t calc_beats(input word_t length);
        word_t raw;
        raw = length >> $clog2(WORDS_PER_QWORD);
        if (raw > word_t'(MAX_BEATS)) begin
            return beat_cnt_t'(MAX_BEATS);
        end
        return raw[BEAT_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/dma_write_engine_if.sv
// ---------------------------------------------------------------------------
// dma_write_engine_if
//   Bundles the CPU command, bus request/grant, memory port-2 and device
//   buffer signals of the DMA write engine.
//   master : engine side (drives cmd_ready, br, write_q, address, qdata,
//            dev_index, dma_done, busy)
//   slave  : environment side (CPU, memory, device buffer)
// ---------------------------------------------------------------------------
interface dma_write_engine_if;
    import dma_write_engine_pkg::*;

    // CPU command channel
    logic     cmd_valid;
    logic     cmd_ready;
    word_t    cmd_addr;
    word_t    cmd_length;

    // Bus arbitration
    logic     br;
    logic     bg;

    // Memory port 2
    logic     write_q;
    word_t    address;
    qword_t   qdata;
    logic     mem_ready;
    logic     mem_ack;

    // Device buffer
    dev_idx_t dev_index;
    qword_t   dev_qdata;

    // Status / interrupt
    logic     dma_done;
    logic     busy;

    modport master (
        input  cmd_valid, cmd_addr, cmd_length, bg, mem_ready, mem_ack, dev_qdata,
        output cmd_ready, br, write_q, address, qdata, dev_index, dma_done, busy
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_length, bg, mem_ready, mem_ack, dev_qdata,
        input  cmd_ready, br, write_q, address, qdata, dev_index, dma_done, busy
    );

endinterface

// File: rtl/dma_write_engine_beat_counter.sv
// ---------------------------------------------------------------------------
// dma_beat_counter
//   Holds the per-beat transfer position: memory word address, device buffer
//   index and remaining beat count.
//   clk, reset_n  : clock, async active-low reset
//   load_i        : start a new transfer from addr_i / beats_i, index 0
//   step_i        : current beat acknowledged, advance to the next one
//   address_o     : word address of the current beat
//   dev_index_o   : device buffer index of the current beat
//   last_o        : exactly one beat remains (a step now empties the count)
// ---------------------------------------------------------------------------
module dma_beat_counter
    import dma_write_engine_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      load_i,
    input  logic      step_i,
    input  word_t     addr_i,
    input  beat_cnt_t beats_i,
    output word_t     address_o,
    output dev_idx_t  dev_index_o,
    output logic      last_o
);

    word_t     addr_q, addr_d;
    dev_idx_t  idx_q, idx_d;
    beat_cnt_t beats_q, beats_d;

    // Load wins over step; the address wraps naturally at 16 bits
    always_comb begin
        addr_d  = addr_q;
        idx_d   = idx_q;
        beats_d = beats_q;
        if (load_i) begin
            addr_d  = addr_i;
            idx_d   = '0;
            beats_d = beats_i;
        end else if (step_i) begin
            addr_d  = addr_q + word_t'(WORDS_PER_QWORD);
            idx_d   = idx_q + 1'b1;
            beats_d = beats_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            idx_q   <= '0;
            beats_q <= '0;
        end else begin
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            beats_q <= beats_d;
        end
    end

    assign address_o   = addr_q;
    assign dev_index_o = idx_q;
    assign last_o      = (beats_q == beat_cnt_t'(1));

endmodule

// File: rtl/dma_write_engine.sv
// ---------------------------------------------------------------------------
// dma_write_engine
//   Bus-master DMA engine on memory port 2. Takes a block-transfer command,
//   requests the bus, writes device-buffer qwords to memory one beat per
//   mem_ack, releases the bus and pulses dma_done.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : dma_write_engine_if.master (command, br/bg, port-2 write,
//              device buffer, dma_done/busy)
//   All outputs are registered except qdata, which is the device data.
// ---------------------------------------------------------------------------
module dma_write_engine
    import dma_write_engine_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    dma_write_engine_if.master bus
);

    state_t    state_q, state_d;
    logic      cmd_ready_q;
    logic      br_q;
    logic      wr_req_q;
    logic      dma_done_q;
    logic      busy_q;

    logic      load;
    logic      step;
    logic      last_beat;
    beat_cnt_t cmd_beats;

    assign cmd_beats = calc_beats(bus.cmd_length);

    dma_beat_counter u_beat_counter (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (load),
        .step_i      (step),
        .addr_i      (bus.cmd_addr),
        .beats_i     (cmd_beats),
        .address_o   (bus.address),
        .dev_index_o (bus.dev_index),
        .last_o      (last_beat)
    );

    // Next-state logic. A write is only launched from ISSUE with the grant
    // still present, and WAIT always runs to mem_ack so a beat is never
    // abandoned; a grant lost during WAIT sends us back to REQ afterwards.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    load    = 1'b1;
                    state_d = (cmd_beats == '0) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.bg) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!bus.bg) begin
                    state_d = ST_REQ;
                end else if (bus.mem_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ack) begin
                    step = 1'b1;
                    if (last_beat) begin
                        state_d = ST_RELEASE;
                    end else if (bus.bg) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_RELEASE: begin
                // Hold off completion until the CPU has taken the grant back
                if (!bus.bg) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with state_q
    // without a combinational path to the pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            br_q        <= 1'b0;
            wr_req_q    <= 1'b0;
            dma_done_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= (state_d == ST_IDLE);
            br_q        <= (state_d == ST_REQ) || (state_d == ST_ISSUE) ||
                           (state_d == ST_WAIT);
            wr_req_q    <= (state_d == ST_WAIT);
            dma_done_q  <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.br        = br_q;
    assign bus.write_q   = wr_req_q;
    assign bus.dma_done  = dma_done_q;
    assign bus.busy      = busy_q;
    assign bus.qdata     = bus.dev_qdata;

endmodule

// File: tb/tb_dma_write_engine.sv
// ---------------------------------------------------------------------------
// tb_dma_write_engine
//   Self-checking bench for dma_write_engine: a CPU grant responder, a memory
//   ack responder, a write monitor and a transfer-level reference model.
// ---------------------------------------------------------------------------
module tb_dma_write_engine;
    import dma_write_engine_pkg::*;

    logic clk;
    logic reset_n;

    dma_write_engine_if bus();

    dma_write_engine dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device buffer contents, indexed combinationally by the engine
    logic [63:0] devMem [16];
    assign bus.dev_qdata = devMem[bus.dev_index];

    typedef struct {
        logic [15:0] addr;
        logic [3:0]  idx;
        logic [63:0] data;
    } wrRec_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] len;
        int          bgD;
        int          ackD;
        int          expBeats;
        logic [15:0] expLastAddr;
    } vec_t;

    int checkCount = 0;
    int errorCount = 0;

    // Responder controls
    int bgDelay = 0;
    int ackDelay = 1;
    bit bgForceLow = 0;
    bit memReadyForceLow = 0;

    // Monitor results
    wrRec_t writeLog [$];
    int doneCount = 0;
    int bgViolations = 0;
    int stabilityErrors = 0;
    bit brSeen = 0;
    bit wqSeen = 0;
    bit brAtDone = 0;
    bit busyAtDone = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearLog();
        writeLog.delete();
        doneCount = 0;
        bgViolations = 0;
        stabilityErrors = 0;
        brSeen = 0;
        wqSeen = 0;
        brAtDone = 0;
        busyAtDone = 0;
    endtask

    // CPU: grants the bus bgDelay cycles after seeing br, takes it back as
    // soon as br drops (or when the test forces it low).
    initial begin
        int brCycles;
        brCycles = 0;
        bus.bg = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!reset_n || !bus.br || bgForceLow) begin
                bus.bg = 1'b0;
                brCycles = 0;
            end else if (!bus.bg) begin
                if (brCycles >= bgDelay) bus.bg = 1'b1;
                else brCycles++;
            end
        end
    end

    // Memory: one mem_ack pulse ackDelay cycles after write_q goes high
    initial begin
        int ackCycles;
        ackCycles = 0;
        bus.mem_ack = 1'b0;
        bus.mem_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.mem_ready = !memReadyForceLow;
            if (!reset_n || !bus.write_q) begin
                ackCycles = 0;
            end else begin
                ackCycles++;
                if (ackCycles == ackDelay) bus.mem_ack = 1'b1;
            end
        end
    end

    // Monitor: logs each new write, checks grant at launch and stability
    initial begin
        bit          prevWrite;
        bit          prevBg;
        logic [15:0] prevAddr;
        logic [3:0]  prevIdx;
        prevWrite = 0;
        prevBg = 0;
        prevAddr = '0;
        prevIdx = '0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (bus.write_q && !prevWrite) begin
                    writeLog.push_back('{bus.address, bus.dev_index, bus.qdata});
                    if (!prevBg) bgViolations++;
                end
                if (bus.write_q && prevWrite &&
                    (bus.address !== prevAddr || bus.dev_index !== prevIdx))
                    stabilityErrors++;
                if (bus.dma_done) begin
                    doneCount++;
                    brAtDone = bus.br;
                    busyAtDone = bus.busy;
                end
                if (bus.br) brSeen = 1;
                if (bus.write_q) wqSeen = 1;
            end
            prevWrite = bus.write_q;
            prevBg = bus.bg;
            prevAddr = bus.address;
            prevIdx = bus.dev_index;
        end
    end

    task automatic sendCommand(input logic [15:0] addr, input logic [15:0] len);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        while (!bus.cmd_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.cmd_ready) checkOutput("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_addr = addr;
        bus.cmd_length = len;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask

    // Returns the number of negedges from the accept edge to dma_done
    task automatic waitDone(input string tag, output int latency);
        latency = 0;
        while (latency < 1000) begin
            @(negedge clk);
            latency++;
            #1;
            if (doneCount > 0) break;
        end
        if (doneCount == 0) checkOutput({tag, "_done_timeout"}, 64'd0, 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] len,
                                 input int bgD, input int ackD, output int latency);
        bgDelay = bgD;
        ackDelay = ackD;
        @(posedge clk); #1;
        clearLog();
        sendCommand(addr, len);
        waitDone("xfer", latency);
    endtask

    // Reference: beats = min(len/4, 16); beat i writes devMem[i] at addr+4i
    task automatic verifyTransfer(input string tag, input logic [15:0] addr,
                                  input logic [15:0] len);
        int nb;
        logic [15:0] expAddr;
        nb = int'(len) / 4;
        if (nb > 16) nb = 16;
        checkOutput({tag, "_writes"}, 64'(writeLog.size()), 64'(nb));
        for (int i = 0; i < writeLog.size() && i < nb; i++) begin
            expAddr = 16'((int'(addr) + 4 * i) % 65536);
            checkOutput({tag, "_addr"}, 64'(writeLog[i].addr), 64'(expAddr));
            checkOutput({tag, "_index"}, 64'(writeLog[i].idx), 64'(i));
            checkOutput({tag, "_qdata"}, writeLog[i].data, devMem[i]);
        end
        checkOutput({tag, "_done_pulses"}, 64'(doneCount), 64'd1);
        checkOutput({tag, "_br_seen"}, 64'(brSeen), 64'(nb > 0));
        checkOutput({tag, "_wq_seen"}, 64'(wqSeen), 64'(nb > 0));
        checkOutput({tag, "_br_at_done"}, 64'(brAtDone), 64'd0);
        checkOutput({tag, "_busy_at_done"}, 64'(busyAtDone), 64'd1);
        checkOutput({tag, "_grant_at_issue"}, 64'(bgViolations), 64'd0);
        checkOutput({tag, "_stable"}, 64'(stabilityErrors), 64'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs [8];
        int lat;
        int guard;
        int stray;
        logic [15:0] rAddr;
        logic [15:0] rLen;

        for (int i = 0; i < 16; i++) devMem[i] = {$urandom, $urandom};

        vecs[0] = '{16'h0017, 16'd12,     1, 2, 3,  16'h001F};
        vecs[1] = '{16'h0000, 16'd0,      0, 1, 0,  16'h0000};
        vecs[2] = '{16'h1234, 16'd3,      0, 1, 0,  16'h0000};
        vecs[3] = '{16'hFFFC, 16'd8,      2, 1, 2,  16'h0000};
        vecs[4] = '{16'h0040, 16'd100,    0, 1, 16, 16'h007C};
        vecs[5] = '{16'h2001, 16'd7,      3, 3, 1,  16'h2001};
        vecs[6] = '{16'hFFF8, 16'hFFFF,   1, 2, 16, 16'h0034};
        vecs[7] = '{16'h8000, 16'd64,     0, 1, 16, 16'h803C};

        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_length = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk);
        checkOutput("reset_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        checkOutput("reset_br", 64'(bus.br), 64'd0);
        checkOutput("reset_write_q", 64'(bus.write_q), 64'd0);
        checkOutput("reset_dma_done", 64'(bus.dma_done), 64'd0);
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_address", 64'(bus.address), 64'd0);
        checkOutput("reset_dev_index", 64'(bus.dev_index), 64'd0);
        checkOutput("reset_qdata", bus.qdata, devMem[0]);

        // Table of transfers with hand-computed beat counts and last address
        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].len, vecs[v].bgD, vecs[v].ackD, lat);
            checkOutput("vec_beats", 64'(writeLog.size()), 64'(vecs[v].expBeats));
            if (vecs[v].expBeats > 0 && writeLog.size() > 0)
                checkOutput("vec_last_addr", 64'(writeLog[writeLog.size()-1].addr),
                            64'(vecs[v].expLastAddr));
            if (vecs[v].expBeats == 0)
                checkOutput("vec_zero_len_latency", 64'(lat >= 1 && lat <= 2), 64'd1);
            verifyTransfer("vec", vecs[v].addr, vecs[v].len);
        end

        // Reset asserted while a write is outstanding
        bgDelay = 0;
        ackDelay = 30;
        @(posedge clk); #1;
        clearLog();
        sendCommand(16'h0300, 16'd16);
        guard = 0;
        while (!bus.write_q && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_reached_wait", 64'(bus.write_q), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("rst_br", 64'(bus.br), 64'd0);
        checkOutput("rst_write_q", 64'(bus.write_q), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b1;
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.br || bus.write_q || bus.busy || !bus.cmd_ready) stray++;
        end
        checkOutput("rst_no_resume", 64'(stray), 64'd0);

        // Grant withdrawn while the first of three beats is outstanding
        bgDelay = 0;
        ackDelay = 4;
        @(posedge clk); #1;
        clearLog();
        sendCommand(16'h0500, 16'd12);
        guard = 0;
        while (!bus.write_q && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bgdrop_first_write", 64'(bus.write_q), 64'd1);
        bgForceLow = 1;
        guard = 0;
        while (!bus.mem_ack && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("bgdrop_ack_seen", 64'(bus.mem_ack), 64'd1);
        stray = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.write_q || !bus.br) stray++;
        end
        checkOutput("bgdrop_hold", 64'(stray), 64'd0);
        checkOutput("bgdrop_dev_index", 64'(bus.dev_index), 64'd1);
        checkOutput("bgdrop_address", 64'(bus.address), 64'h0504);
        bgForceLow = 0;
        waitDone("bgdrop", lat);
        verifyTransfer("bgdrop", 16'h0500, 16'd12);

        // Command pulsed while busy, memory not ready for a while
        bgDelay = 0;
        ackDelay = 1;
        memReadyForceLow = 1;
        @(posedge clk); #1;
        clearLog();
        sendCommand(16'h0040, 16'd8);
        guard = 0;
        while (!bus.bg && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("busycmd_granted", 64'(bus.bg), 64'd1);
        @(posedge clk); #1;
        bus.cmd_addr = 16'h0100;
        bus.cmd_length = 16'd4;
        bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.write_q) stray++;
        end
        checkOutput("busycmd_no_write_unready", 64'(stray), 64'd0);
        memReadyForceLow = 0;
        waitDone("busycmd", lat);
        verifyTransfer("busycmd", 16'h0040, 16'd8);
        checkOutput("busycmd_idle_after", 64'(bus.cmd_ready && !bus.busy), 64'd1);

        // Randomized transfers against the reference model
        for (int r = 0; r < 10; r++) begin
            rAddr = 16'($urandom);
            rLen = 16'($urandom_range(0, 80));
            applyStimulus(rAddr, rLen, int'($urandom_range(0, 3)),
                          int'($urandom_range(1, 4)), lat);
            verifyTransfer("rand", rAddr, rLen);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
